decoder_strobe: RTL and testbench
=================================

// Module: decoder_strobe
// PURPOSE
//  Registered N-to-2^N binary-to-one-hot decoder; inverse of the 8-to-3 encoder.
//  Accepts a binary code over a valid/ready handshake and drives the one-hot line
//  for PULSE_LEN cycles, then idles GAP_LEN cycles before accepting the next code.
//  Used as a line-select / strobe generator whose output feeds the encoder for
//  round-trip checks.
// PARAMETERS
//  N          3   code width; output width is 2**N
//  PULSE_LEN  1   cycles the one-hot output is held (>=1)
//  GAP_LEN    0   idle cycles forced after each pulse (>=0)
// PORTS
//  clk         in   1     rising-edge clock; only clock
//  rst_n       in   1     asynchronous active-low reset
//  in_valid    in   1     in_code/in_en valid this cycle
//  in_ready    out  1     block can accept a code this cycle
//  in_code     in   N     binary code to decode
//  in_en       in   1     decode enable, sampled with in_code; 0 = all-zero output
//  out_onehot  out  2**N  registered one-hot (or all-zero) output
//  out_valid   out  1     high while out_onehot is being driven
//  busy        out  1     high in HOLD or GAP
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, out_onehot=0, out_valid=0, busy=0,
//    in_ready=0 while rst_n low, counters=0, captured code=0. First cycle after
//    release: in_ready=1.
//  - FSM states: IDLE, HOLD, GAP.
//    IDLE: in_ready=1. Accept when in_valid&&in_ready at edge -> HOLD;
//      capture code/en; cnt=PULSE_LEN-1.
//    HOLD: out_valid=1, out_onehot = in_en_cap ? (1<<code_cap) : 0.
//      cnt==0 -> GAP (cnt=GAP_LEN-1) if GAP_LEN>0, else IDLE; otherwise cnt--.
//    GAP: out_valid=0, out_onehot=0; cnt==0 -> IDLE; otherwise cnt--.
//  - Latency: accept edge -> out_valid/out_onehot high from the next cycle (1 cycle).
//  - out_onehot and out_valid are registered outputs. No combinational path
//    from in_* to out_*.
//  - in_ready=0 in HOLD and GAP. in_valid there is ignored; the code is not
//    queued, and the source holds it.
//  - Throughput: one code per 1+PULSE_LEN+GAP_LEN cycles (IDLE cycle included).
//  - All 2**N codes are legal. Output has exactly one bit set, or zero bits if in_en=0.
//    Bit k corresponds to code k (LSB = code 0).
//  - in_code/in_en changes outside the accept edge have no effect on the output.
//  - Counter width = clog2(max(PULSE_LEN,GAP_LEN,2)). No wrap: cnt never decrements below 0.
//  - rst_n asserted mid-HOLD/GAP: outputs clear immediately (asynchronously).
//    The pulse in progress is dropped and not resumed.
//  - in_valid high during the first cycle after reset release is accepted
//    at that edge.
// TESTING
//  1. Reset: rst_n=0 -> out_onehot=0, out_valid=0, busy=0, in_ready=0.
//     Release -> in_ready=1 on the next cycle.
//  2. Defaults (PULSE_LEN=1, GAP_LEN=0): codes 0..7 with in_en=1, one per
//     2 cycles -> out_onehot = 00000001..10000000, each for exactly 1 cycle
//     after accept.
//  3. PULSE_LEN=3, GAP_LEN=2: code 5 -> out_onehot=00100000 for 3 cycles,
//     then 0 for 2 cycles with busy=1, then in_ready=1 (6-cycle period).
//  4. in_en=0, code 6 -> out_valid=1 for PULSE_LEN cycles, out_onehot=00000000.
//  5. in_valid held with code 2, then changed to 7 during HOLD -> 7 is accepted
//     only when in_ready returns. Output is 00000100 then 10000000,
//     with no corruption mid-pulse.
//  6. Round trip: decoder output -> encoder input for codes 0..7 -> encoder
//     b == code. rst_n pulsed low mid-HOLD -> out_onehot=0 in the same cycle.

Source files
------------

// File: rtl/decoder_strobe.sv
// Registered N-to-2**N one-hot strobe generator with a valid/ready handshake.
// Each accepted code drives its one-hot line for PULSE_LEN cycles, then the block idles for GAP_LEN cycles.
module decoder_strobe #(
  parameter int N         = 3,
  parameter int PULSE_LEN = 1,
  parameter int GAP_LEN   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_code,
  input  logic             in_en,
  output logic [2**N-1:0]  out_onehot,
  output logic             out_valid,
  output logic             busy
);

  localparam int W       = 2 ** N;
  localparam int MAX_LEN = (PULSE_LEN > GAP_LEN) ? ((PULSE_LEN > 2) ? PULSE_LEN : 2)
                                                 : ((GAP_LEN   > 2) ? GAP_LEN   : 2);
  localparam int CW      = $clog2(MAX_LEN);

  localparam logic [CW-1:0] PULSE_INIT = CW'(PULSE_LEN - 1);
  localparam logic [CW-1:0] GAP_INIT   = CW'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [1:0]    state_q,  state_d;
  logic [CW-1:0] cnt_q,    cnt_d;
  logic [W-1:0]  onehot_q, onehot_d;
  logic          valid_q,  valid_d;
  logic [W-1:0]  decoded;

  always_comb begin
    decoded = '0;
    if (in_en) decoded[in_code] = 1'b1;
  end

  // The pulse value is decoded once at the accept edge and held in onehot_q,
  // so later in_code/in_en activity cannot disturb a pulse in progress.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    cnt_d    = cnt_q;
    onehot_d = onehot_q;
    valid_d  = valid_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d  = S_HOLD;
          cnt_d    = PULSE_INIT;
          onehot_d = decoded;
          valid_d  = 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          onehot_d = '0;
          valid_d  = 1'b0;
          if (GAP_LEN > 0) begin
            state_d = S_GAP;
            cnt_d   = GAP_INIT;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: begin
        state_d  = S_IDLE;
        cnt_d    = '0;
        onehot_d = '0;
        valid_d  = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      onehot_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      onehot_q <= onehot_d;
      valid_q  <= valid_d;
    end
  end

  // Gating with rst_n keeps in_ready low throughout reset, while letting the
  // first edge after release accept a code.
  assign in_ready   = rst_n && (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign out_onehot = onehot_q;
  assign out_valid  = valid_q;

endmodule

// File: tb/tb_decoder_strobe.sv
// Self-checking bench for decoder_strobe: default timing (A) and PULSE_LEN=3/GAP_LEN=2 (B).
// Expected values come from the strobe timeline (accept, P pulse cycles, G gap cycles, ready).
module tb_decoder_strobe;

  localparam int PA = 1, GA = 0;
  localparam int PB = 3, GB = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       a_valid = 1'b0, a_en = 1'b0, a_ready, a_ovalid, a_busy;
  logic [2:0] a_code = '0;
  logic [7:0] a_onehot;
  logic       b_valid = 1'b0, b_en = 1'b0, b_ready, b_ovalid, b_busy;
  logic [2:0] b_code = '0;
  logic [7:0] b_onehot;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  decoder_strobe #(.N(3), .PULSE_LEN(PA), .GAP_LEN(GA)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_ready(a_ready),
    .in_code(a_code), .in_en(a_en), .out_onehot(a_onehot),
    .out_valid(a_ovalid), .busy(a_busy)
  );

  decoder_strobe #(.N(3), .PULSE_LEN(PB), .GAP_LEN(GB)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_ready(b_ready),
    .in_code(b_code), .in_en(b_en), .out_onehot(b_onehot),
    .out_valid(b_ovalid), .busy(b_busy)
  );

  function automatic logic       f_ready(bit sel);  return sel ? b_ready  : a_ready;  endfunction
  function automatic logic       f_ovalid(bit sel); return sel ? b_ovalid : a_ovalid; endfunction
  function automatic logic       f_busy(bit sel);   return sel ? b_busy   : a_busy;   endfunction
  function automatic logic [7:0] f_onehot(bit sel); return sel ? b_onehot : a_onehot; endfunction

  // Reference 8-to-3 encoder for round-trip checks.
  function automatic logic [2:0] encode(logic [7:0] oh);
    logic [2:0] r = '0;
    for (int k = 0; k < 8; k++) if (oh[k]) r = 3'(k);
    return r;
  endfunction

  task automatic drive(bit sel, logic v, logic [2:0] c, logic e);
    if (sel) begin b_valid = v; b_code = c; b_en = e; end
    else     begin a_valid = v; a_code = c; a_en = e; end
  endtask

  task automatic check_state(string name, bit sel, logic [7:0] exp_oh, logic exp_v,
                             logic exp_busy, logic exp_rdy);
    n_checks++;
    if (f_onehot(sel) !== exp_oh || f_ovalid(sel) !== exp_v ||
        f_busy(sel) !== exp_busy || f_ready(sel) !== exp_rdy) begin
      n_fail++;
      $display("FAIL %s dut%0d t=%0t: onehot=%b valid=%b busy=%b ready=%b, expected onehot=%b valid=%b busy=%b ready=%b",
               name, sel, $time, f_onehot(sel), f_ovalid(sel), f_busy(sel), f_ready(sel),
               exp_oh, exp_v, exp_busy, exp_rdy);
    end
  endtask

  // One transaction, entered and left on a falling edge. After the accept edge
  // the input is either dropped and scrambled, or kept valid with next_code.
  task automatic txn(string name, bit sel, logic [2:0] code, logic en,
                     bit keep, logic [2:0] next_code, bit rt);
    int p = sel ? PB : PA;
    int g = sel ? GB : GA;
    logic [7:0] exp_oh = en ? (8'd1 << code) : 8'd0;
    int waited = 0;
    drive(sel, 1'b1, code, en);
    while (f_ready(sel) !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 20) begin
      n_checks++; n_fail++;
      $display("FAIL %s dut%0d: in_ready not seen within 20 cycles", name, sel);
      drive(sel, 1'b0, code, en);
      return;
    end
    @(negedge clk);
    if (keep) drive(sel, 1'b1, next_code, 1'b1);
    else      drive(sel, 1'b0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    for (int i = 0; i < p; i++) begin
      check_state({name, "_hold"}, sel, exp_oh, 1'b1, 1'b1, 1'b0);
      if (rt && en) begin
        n_checks++;
        if (encode(f_onehot(sel)) !== code) begin
          n_fail++;
          $display("FAIL %s_roundtrip: encoded=%0d expected=%0d", name, encode(f_onehot(sel)), code);
        end
      end
      @(negedge clk);
      if (!keep) drive(sel, 1'b0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < g; i++) begin
      check_state({name, "_gap"}, sel, 8'd0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
    end
    if (!keep) check_state({name, "_idle"}, sel, 8'd0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    check_state("reset_a", 0, 8'd0, 1'b0, 1'b0, 1'b0);
    check_state("reset_b", 1, 8'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check_state("reset_held_a", 0, 8'd0, 1'b0, 1'b0, 1'b0);
    // Release with a code already pending on A: it must be accepted at the first edge.
    drive(0, 1'b1, 3'd3, 1'b1);
    rst_n = 1'b1;
    #1;
    check_state("release_b", 1, 8'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check_state("first_edge_accept", 0, 8'b0000_1000, 1'b1, 1'b1, 1'b0);
    drive(0, 1'b0, 3'd0, 1'b0);
    @(negedge clk);
    check_state("first_edge_done", 0, 8'd0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_defaults;
    for (int c = 0; c < 8; c++) txn("defaults", 0, 3'(c), 1'b1, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic test_pulse_gap;
    txn("pulse_gap_code5", 1, 3'd5, 1'b1, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic test_disabled;
    txn("disabled_a", 0, 3'd6, 1'b0, 1'b0, 3'd0, 1'b0);
    txn("disabled_b", 1, 3'd6, 1'b0, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic test_back_to_back;
    txn("b2b_first", 1, 3'd2, 1'b1, 1'b1, 3'd7, 1'b0);
    txn("b2b_second", 1, 3'd7, 1'b1, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 24; i++) begin
      txn("random", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
          1'($urandom_range(0, 3) != 0), 1'b0, 3'd0, 1'b0);
    end
  endtask

  task automatic test_round_trip;
    for (int c = 0; c < 8; c++) txn("roundtrip", 0, 3'(c), 1'b1, 1'b0, 3'd0, 1'b1);
    drive(1, 1'b1, 3'd4, 1'b1);
    @(negedge clk);
    drive(1, 1'b0, 3'd0, 1'b0);
    @(negedge clk);
    check_state("midhold_before", 1, 8'b0001_0000, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    check_state("midhold_async_clear", 1, 8'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_state("midhold_not_resumed", 1, 8'd0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset;
    test_defaults;
    test_pulse_gap;
    test_disabled;
    test_back_to_back;
    test_random;
    test_round_trip;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
